hazard_scoreboard: RTL

Parametrised RAW/WAW hazard detector for the RV32I pipeline's decode stage. It replaces single-cycle load-use detection with a per-register latency scoreboard, so loads, multi-cycle units and configurable memory latency share one stall mechanism. The block sits beside the ID stage: it samples the decoding instruction's operands, tracks in-flight producers with countdown counters, and drives the IF/ID stall.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_reg_counter.sv | 29 ++
 rtl/hazard_scoreboard.sv | 76 +++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults and result-latency classes for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned LAT_W_DEF  = 3;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;
  localparam int unsigned LAT_DIV  = 7;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to scoreboard signal bundle: decode operands in, stall and status out.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  localparam int unsigned NREGS = 2**REG_AW;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic [LAT_W-1:0]  id_lat;
  logic              id_flush;
  logic              pipe_hold;
  logic              stall;
  logic [NREGS-1:0]  busy_mask;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_lat, id_flush, pipe_hold,
    input  stall, busy_mask, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_lat, id_flush, pipe_hold,
    output stall, busy_mask, stall_count
  );

endinterface

// File: rtl/hazard_reg_counter.sv
// Per-register result-latency down-counter with load, hold and a pending flag.
module hazard_reg_counter #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             nz
);

  assign nz = (cnt != '0);

  // A same-cycle load takes priority over the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (nz) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW hazard scoreboard: per-register latency counters drive the IF/ID stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  sb
);

  localparam int unsigned NREGS = 2**REG_AW;

  logic [LAT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] busy;
  logic             raw_hit;
  logic             waw_hit;
  logic             stall;
  logic             issue;
  logic [CNT_W-1:0] stall_cnt_q;

  // x0 is hardwired: never pending, never loaded.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    hazard_reg_counter #(
      .LAT_W (LAT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .hold     (sb.pipe_hold),
      .load     (issue && (sb.id_rd == REG_AW'(r))),
      .load_val (sb.id_lat),
      .cnt      (cnt[r]),
      .nz       (busy[r])
    );
  end

  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    stall   = 1'b0;
    issue   = 1'b0;

    if (sb.id_rs1_used && (sb.id_rs1 != '0) && busy[sb.id_rs1]) begin
      raw_hit = 1'b1;
    end
    if (sb.id_rs2_used && (sb.id_rs2 != '0) && busy[sb.id_rs2]) begin
      raw_hit = 1'b1;
    end
    // A younger writer finishing before the pending one would be overwritten.
    if (sb.id_rd_we && (sb.id_rd != '0) && (cnt[sb.id_rd] > sb.id_lat)) begin
      waw_hit = 1'b1;
    end

    stall = sb.id_valid && !sb.id_flush && (raw_hit || waw_hit);
    issue = sb.id_valid && !stall && !sb.id_flush && !sb.pipe_hold &&
            sb.id_rd_we && (sb.id_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign sb.stall       = stall;
  assign sb.busy_mask   = busy;
  assign sb.stall_count = stall_cnt_q;

endmodule
